// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier: start + operands in, busy/done/product out.
// Master drives the request side; the multiplier (slave) drives status and result.
interface shift_add_multiplier_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier built on one 8-bit adder; 8-cycle latency, 9-cycle throughput.
// No backpressure: start is ignored while busy; product is registered and holds until the next completion.

module eight_bit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
endmodule

module shift_add_multiplier (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  mul_if
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  m_q;
    logic [7:0]  a_q;
    logic [7:0]  q_q;
    logic        c_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] product_q;

    logic [7:0]  sum;
    logic        cout;
    logic [8:0]  acc_d;
    logic [7:0]  a_d;
    logic [7:0]  q_d;

    eight_bit_adder u_adder (
        .a_i    (a_q),
        .b_i    (m_q),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // {C',A'} then one right shift of the 17-bit {C',A',Q}; C is cleared every step so the
    // no-add path carries zero.
    always_comb begin
        acc_d = q_q[0] ? {cout, sum} : {c_q, a_q};
        a_d   = acc_d[8:1];
        q_d   = {acc_d[0], q_q[7:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    c_q   <= 1'b0;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= {a_d, q_d};
                    end
                end
                default: begin
                    // IDLE and DONE accept a new request identically.
                    done_q <= 1'b0;
                    if (mul_if.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        m_q     <= mul_if.a;
                        q_q     <= mul_if.b;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign mul_if.busy    = busy_q;
    assign mul_if.done    = done_q;
    assign mul_if.product = product_q;
endmodule
